// File: rtl/atm_cash_dispenser.sv
// Note dispenser: greedy breakdown of an authorised amount against the on-board
// inventory, then metered note-by-note delivery over a valid/ack handshake.
module atm_cash_dispenser #(
   parameter int DENOM_HI  = 100,
   parameter int DENOM_MID = 50,
   parameter int DENOM_LO  = 10,
   parameter int INIT_CNT  = 20,
   parameter int MAX_NOTES = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dispense_req,
   input  logic [15:0] dispense_amount,
   input  logic        refill,
   input  logic        note_ack,
   output logic        note_valid,
   output logic [1:0]  note_sel,
   output logic        busy,
   output logic        dispense_ok,
   output logic        dispense_fail,
   output logic [7:0]  cnt_hi,
   output logic [7:0]  cnt_mid,
   output logic [7:0]  cnt_lo
);

   typedef enum logic [2:0] {ST_IDLE, ST_PLAN, ST_DISPENSE, ST_DONE, ST_REJECT} state_t;

   // Per-denomination arrays are indexed by note_sel: 2=HI, 1=MID, 0=LO.
   localparam logic [7:0]       INIT_VAL  = 8'(INIT_CNT);
   localparam logic [9:0]       MAX_TOTAL = 10'(MAX_NOTES);
   localparam logic [2:0][15:0] DENOM     = {16'(DENOM_HI), 16'(DENOM_MID), 16'(DENOM_LO)};

   state_t          state_q, state_d;
   logic [15:0]     rem_q, rem_d;
   logic [2:0][7:0] plan_q, plan_d;
   logic [2:0][7:0] cnt_q, cnt_d;
   logic [9:0]      total_q, total_d;

   logic            pick_ok;
   logic [1:0]      pick_idx;
   logic            over_limit;
   logic [1:0]      out_sel;
   logic            xfer;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         plan_q  <= '0;
         cnt_q   <= {3{INIT_VAL}};
         total_q <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         plan_q  <= plan_d;
         cnt_q   <= cnt_d;
         total_q <= total_d;
      end
   end

   // Highest denomination that still fits the remainder and has stock left.
   always_comb begin
      pick_ok  = 1'b0;
      pick_idx = 2'd0;
      for (int i = 2; i >= 0; i--) begin
         if (!pick_ok && rem_q >= DENOM[i] && plan_q[i] < cnt_q[i]) begin
            pick_ok  = 1'b1;
            pick_idx = 2'(i);
         end
      end
   end

   assign over_limit = (total_q >= MAX_TOTAL) && (rem_q != '0);
   assign out_sel    = (plan_q[2] != '0) ? 2'd2 : ((plan_q[1] != '0) ? 2'd1 : 2'd0);
   assign xfer       = (state_q == ST_DISPENSE) && note_ack;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (dispense_req) state_d = ST_PLAN;
         ST_PLAN: begin
            if (over_limit)                               state_d = ST_REJECT;
            else if (pick_ok)                             state_d = ST_PLAN;
            else if (rem_q == '0 && total_q != '0)        state_d = ST_DISPENSE;
            else                                          state_d = ST_REJECT;
         end
         ST_DISPENSE: if (xfer && total_q == 10'd1) state_d = ST_DONE;
         ST_DONE:     state_d = ST_IDLE;
         ST_REJECT:   state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rem_d   = rem_q;
      plan_d  = plan_q;
      cnt_d   = cnt_q;
      total_d = total_q;
      case (state_q)
         ST_IDLE: begin
            if (dispense_req) begin
               rem_d   = dispense_amount;
               plan_d  = '0;
               total_d = '0;
            end else if (refill) begin
               cnt_d = {3{INIT_VAL}};
            end
         end
         ST_PLAN: begin
            if (!over_limit && pick_ok) begin
               plan_d[pick_idx] = plan_q[pick_idx] + 8'd1;
               rem_d            = rem_q - DENOM[pick_idx];
               total_d          = total_q + 10'd1;
            end
         end
         ST_DISPENSE: begin
            if (xfer) begin
               plan_d[out_sel] = plan_q[out_sel] - 8'd1;
               cnt_d[out_sel]  = cnt_q[out_sel] - 8'd1;
               total_d         = total_q - 10'd1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      note_valid    = (state_q == ST_DISPENSE);
      note_sel      = (state_q == ST_DISPENSE) ? out_sel : 2'd0;
      busy          = (state_q != ST_IDLE);
      dispense_ok   = (state_q == ST_DONE);
      dispense_fail = (state_q == ST_REJECT);
      cnt_hi        = cnt_q[2];
      cnt_mid       = cnt_q[1];
      cnt_lo        = cnt_q[0];
   end

endmodule
